// File: rtl/registro_universal_param.sv
`default_nettype none
// ============================================================================
// Module      : registro_universal_param
// Description : Parametrised universal shift register.
//               Supports serial shift, rotate, parallel load and hold in both
//               directions. It also has a registered serial output and a
//               shift counter that pulses listo when a frame of ANCHO shifts
//               completes.
// Revision    : 1.0 - initial release
// ============================================================================
module registro_universal_param #(
    parameter  int ANCHO = 8,
    localparam int CW    = $clog2(ANCHO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             dir,
    input  logic             s_in,
    input  logic [1:0]       modo,
    input  logic [ANCHO-1:0] d,
    output logic [ANCHO-1:0] q,
    output logic             s_out,
    output logic [CW-1:0]    cuenta,
    output logic             listo
);

    localparam logic [1:0]    c_MODO_SERIE = 2'b00;
    localparam logic [1:0]    c_MODO_CARGA = 2'b10;
    localparam logic [CW-1:0] c_ULTIMO     = CW'(ANCHO - 1);

    logic [ANCHO-1:0] datos_q,  datos_d;
    logic             s_out_q,  s_out_d;
    logic [CW-1:0]    cuenta_q, cuenta_d;
    logic             listo_q,  listo_d;

    logic             w_bit_sale;
    logic             w_bit_entra;
    logic             w_desplaza;

    // Bit leaving the register and bit entering it for the current direction.
    // A rotate feeds the outgoing bit back in, so s_in is never consulted.
    always_comb begin
        w_bit_sale  = dir ? datos_q[0] : datos_q[ANCHO-1];
        w_bit_entra = (modo == c_MODO_SERIE) ? s_in : w_bit_sale;
        w_desplaza  = ~modo[1];
    end

    // Next state: shift/rotate, load or hold. listo is a single-cycle pulse.
    always_comb begin
        datos_d  = datos_q;
        s_out_d  = s_out_q;
        cuenta_d = cuenta_q;
        listo_d  = 1'b0;
        if (enb) begin
            if (w_desplaza) begin
                datos_d = dir ? {w_bit_entra, datos_q[ANCHO-1:1]}
                              : {datos_q[ANCHO-2:0], w_bit_entra};
                s_out_d = w_bit_sale;
                // The counter wraps at ANCHO-1 even if ANCHO is not a power of two.
                if (cuenta_q == c_ULTIMO) begin
                    cuenta_d = '0;
                    listo_d  = 1'b1;
                end else begin
                    cuenta_d = cuenta_q + CW'(1);
                end
            end else if (modo == c_MODO_CARGA) begin
                // A load starts a new frame.
                datos_d  = d;
                cuenta_d = '0;
            end
        end
    end

    // State registers with synchronous reset. Reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            datos_q  <= '0;
            s_out_q  <= 1'b0;
            cuenta_q <= '0;
            listo_q  <= 1'b0;
        end else begin
            datos_q  <= datos_d;
            s_out_q  <= s_out_d;
            cuenta_q <= cuenta_d;
            listo_q  <= listo_d;
        end
    end

    assign q      = datos_q;
    assign s_out  = s_out_q;
    assign cuenta = cuenta_q;
    assign listo  = listo_q;

endmodule
`default_nettype wire

// File: tb/tb_registro_universal_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_registro_universal_param
// Description : Self-checking bench for registro_universal_param.
//               The 8-, 4- and 5-bit instances share the same stimulus. The
//               bench compares them every cycle against an arithmetic model.
//               It also checks hand-computed literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_registro_universal_param;

    logic       clk;
    logic       rst;
    logic       enb;
    logic       dir;
    logic       s_in;
    logic [1:0] modo;
    logic [7:0] d;

    logic [7:0] q8;  logic s8; logic [2:0] c8; logic l8;
    logic [3:0] q4;  logic s4; logic [1:0] c4; logic l4;
    logic [4:0] q5;  logic s5; logic [2:0] c5; logic l5;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model state per instance: register value, serial out, shift count, pulse
    int W [3] = '{8, 4, 5};
    int mq[3];
    int ms[3];
    int mc[3];
    int ml[3];

    registro_universal_param #(.ANCHO(8)) u8 (
        .clk(clk), .rst(rst), .enb(enb), .dir(dir), .s_in(s_in), .modo(modo),
        .d(d), .q(q8), .s_out(s8), .cuenta(c8), .listo(l8)
    );

    registro_universal_param #(.ANCHO(4)) u4 (
        .clk(clk), .rst(rst), .enb(enb), .dir(dir), .s_in(s_in), .modo(modo),
        .d(d[3:0]), .q(q4), .s_out(s4), .cuenta(c4), .listo(l4)
    );

    registro_universal_param #(.ANCHO(5)) u5 (
        .clk(clk), .rst(rst), .enb(enb), .dir(dir), .s_in(s_in), .modo(modo),
        .d(d[4:0]), .q(q5), .s_out(s5), .cuenta(c5), .listo(l5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // The model works on integer arithmetic.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int w, msk, sale, entra;
            w   = W[k];
            msk = (1 << w) - 1;
            if (rst) begin
                mq[k] = 0; ms[k] = 0; mc[k] = 0; ml[k] = 0;
            end else if (!enb) begin
                ml[k] = 0;
            end else if (modo == 2'b10) begin
                mq[k] = int'(d) & msk; mc[k] = 0; ml[k] = 0;
            end else if (modo == 2'b11) begin
                ml[k] = 0;
            end else begin
                sale  = (dir == 1'b0) ? ((mq[k] >> (w - 1)) & 1) : (mq[k] & 1);
                entra = (modo == 2'b00) ? int'(s_in) : sale;
                if (dir == 1'b0) mq[k] = ((mq[k] << 1) | entra) & msk;
                else             mq[k] = (mq[k] >> 1) | (entra << (w - 1));
                ms[k] = sale;
                mc[k] = mc[k] + 1;
                if (mc[k] == w) begin
                    mc[k] = 0; ml[k] = 1;
                end else begin
                    ml[k] = 0;
                end
            end
        end
    end

    // Compare every instance to the model on each falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("q8", int'(q8), mq[0]); chk("s_out8", int'(s8), ms[0]);
            chk("cuenta8", int'(c8), mc[0]); chk("listo8", int'(l8), ml[0]);
            chk("q4", int'(q4), mq[1]); chk("s_out4", int'(s4), ms[1]);
            chk("cuenta4", int'(c4), mc[1]); chk("listo4", int'(l4), ml[1]);
            chk("q5", int'(q5), mq[2]); chk("s_out5", int'(s5), ms[2]);
            chk("cuenta5", int'(c5), mc[2]); chk("listo5", int'(l5), ml[2]);
        end
    end

    // Apply one command and return just after the edge that samples it.
    task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                       input logic dr, input logic si, input logic [7:0] dd);
        rst = r; enb = e; modo = m; dir = dr; s_in = si; d = dd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] t2 [8];
        logic [3:0] leg [5];
        t2  = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
        leg = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};

        cyc(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        chk_on = 1'b1;

        // T1: reset overrides an enabled rotate of 0xFF
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'hFF);
        chk("T1 preload", int'(q8), 'hFF);
        cyc(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        chk("T1 q", int'(q8), 0); chk("T1 s_out", int'(s8), 0);
        chk("T1 cuenta", int'(c8), 0); chk("T1 listo", int'(l8), 0);
        chk("T1 q4", int'(q4), 0);

        // T2: load 0xA5 and rotate left through a full frame
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
            chk("T2 q", int'(q8), int'(t2[i]));
            chk("T2 listo", int'(l8), (i == 7) ? 1 : 0);
        end

        // T3: fill with ones from the left, then drain to the right
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
            chk("T3 q left", int'(q8), (1 << (i + 1)) - 1);
            chk("T3 listo", int'(l8), (i == 7) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00);
            chk("T3 q right", int'(q8), 'hFF >> (i + 1));
            chk("T3 s_out", int'(s8), 1);
        end

        // T4: pause mid-frame with enb=0
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
        repeat (3) cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
        chk("T4 cuenta pre", int'(c8), 3);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 2'b00, 1'b0, (i % 2 == 0) ? 1'b0 : 1'b1, 8'h00);
            chk("T4 q hold", int'(q8), 'h07); chk("T4 cuenta hold", int'(c8), 3);
            chk("T4 s_out hold", int'(s8), 0); chk("T4 listo", int'(l8), 0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
            chk("T4 listo resume", int'(l8), (i == 4) ? 1 : 0);
        end

        // T5: a load mid-frame restarts the count
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
        repeat (5) cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h3C);
        chk("T5 q", int'(q8), 'h3C); chk("T5 cuenta", int'(c8), 0);
        chk("T5 listo", int'(l8), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
            chk("T5 listo frame", int'(l8), (i == 7) ? 1 : 0);
        end

        // T6: legacy 4-bit sequences
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, {4'h0, leg[i]});
            chk("T6 load q4", int'(q4), int'(leg[i]));
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
            chk("T6 shl q4", int'(q4), ('hF << (i + 1)) & 'hF);
            chk("T6 shl listo4", int'(l4), (i == 3) ? 1 : 0);
        end
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h01);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
            chk("T6 rotr q4", int'(q4), 8 >> i);
            chk("T6 rotr listo4", int'(l4), (i == 3) ? 1 : 0);
        end

        // Random traffic. Unused inputs are driven unknown.
        repeat (2000) begin
            logic r, e, dr, si;
            logic [1:0] m;
            logic [7:0] dd;
            r  = ($urandom_range(0, 49) == 0);
            e  = ($urandom_range(0, 99) < 85);
            m  = 2'($urandom_range(0, 3));
            dr = 1'($urandom);
            si = 1'($urandom);
            dd = 8'($urandom);
            if (m != 2'b00) si = 1'bx;
            if (m != 2'b10) dd = 'x;
            if (m[1])       dr = 1'bx;
            cyc(r, e, m, dr, si, dd);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
